// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART TX arbiter: one-hot FSM encoding and parity types.
package uart_tx_pkg;

    typedef logic [4:0] state_t;

    localparam state_t IDLE       = 5'b00001;
    localparam state_t LAUNCH     = 5'b00010;
    localparam state_t WAIT_START = 5'b00100;
    localparam state_t WAIT_END   = 5'b01000;
    localparam state_t GAP        = 5'b10000;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             gnt_valid,
    output logic [IW-1:0]    gnt_idx
);

    logic [IW:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ))
                cand = cand - (IW+1)'(N_REQ);
            if (!gnt_valid && req[cand[IW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter: latches the winner's frame, launches it,
// tracks tx_busy to completion (or start timeout) and enforces an inter-frame gap.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DW            = 8,
    parameter int START_TIMEOUT = 8,
    parameter int GAP_CYCLES    = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      req_data,
    input  logic [N_REQ-1:0]         req_par_en,
    input  logic [N_REQ-1:0]         req_par_typ,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         done,
    input  logic                     tx_busy,
    output logic                     tx_data_valid,
    output logic [DW-1:0]            tx_p_data,
    output logic                     tx_par_en,
    output logic                     tx_par_typ,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     arb_busy,
    output logic                     timeout_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [TW-1:0]    to_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             gnt_valid;
    logic [IW-1:0]    gnt_idx;
    logic [N_REQ-1:0] owner_oh;
    logic             start_expired;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign start_expired = (to_cnt == TW'(START_TIMEOUT));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            ptr        <= '0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            tx_p_data  <= '0;
            tx_par_en  <= 1'b0;
            tx_par_typ <= PAR_EVEN;
            owner_id   <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_valid) begin
                    state      <= LAUNCH;
                    tx_p_data  <= req_data[gnt_idx*DW +: DW];
                    tx_par_en  <= req_par_en[gnt_idx];
                    tx_par_typ <= req_par_typ[gnt_idx];
                    owner_id   <= gnt_idx;
                    ptr        <= (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
                end
                LAUNCH: begin
                    state  <= WAIT_START;
                    to_cnt <= '0;
                end
                // busy wins over an expiring counter in the same cycle
                WAIT_START: begin
                    if (tx_busy)
                        state <= WAIT_END;
                    else if (start_expired) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end else
                        to_cnt <= to_cnt + 1'b1;
                end
                WAIT_END: if (!tx_busy) begin
                    state   <= GAP;
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES-1))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state so an async reset clears them immediately.
    assign owner_oh      = N_REQ'(1) << owner_id;
    assign tx_data_valid = (state == LAUNCH);
    assign arb_busy      = (state != IDLE);
    assign ack           = tx_data_valid ? owner_oh : '0;
    assign done          = (state == WAIT_END && !tx_busy) ? owner_oh : '0;
    assign timeout_err   = (state == WAIT_START) && !tx_busy && start_expired;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: requester queues drive the arbiter, a round-robin reference model
// predicts grant order, and a monitor checks every launch, done and timeout event.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TO  = 8;
    localparam int GAP = 2;
    localparam int IW  = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_par_en = '0;
    logic [N-1:0]    req_par_typ = '0;
    logic            tx_busy = 1'b0;
    logic [N-1:0]    ack, done;
    logic            tx_data_valid, tx_par_en, tx_par_typ, arb_busy, timeout_err;
    logic [DW-1:0]   tx_p_data;
    logic [IW-1:0]   owner_id;

    uart_tx_arbiter #(.N_REQ(N), .DW(DW), .START_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_data(req_data), .req_par_en(req_par_en),
        .req_par_typ(req_par_typ), .ack(ack), .done(done), .tx_busy(tx_busy),
        .tx_data_valid(tx_data_valid), .tx_p_data(tx_p_data), .tx_par_en(tx_par_en),
        .tx_par_typ(tx_par_typ), .owner_id(owner_id), .arb_busy(arb_busy),
        .timeout_err(timeout_err)
    );

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic          pe;
        logic          pt;
    } item_t;

    item_t pend[$];
    item_t batch[$];
    item_t eq[$];
    int    dq[$];
    int    tests = 0, fails = 0, cyc = 0, mp = 0;
    bit    tie_low = 1'b0, exp_to = 1'b0;

    initial forever #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic ev_fail(string name);
        tests++;
        fails++;
        $display("FAIL %s: event state wrong (got unexpected/missing event, expected the other)", name);
    endtask

    task automatic drive_reqs();
        req = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < pend.size(); j++)
                if (pend[j].id == i) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = pend[j].data;
                    req_par_en[i] = pend[j].pe;
                    req_par_typ[i] = pend[j].pt;
                    break;
                end
    endtask

    task automatic load(int id, logic [DW-1:0] d, logic pe, logic pt);
        item_t it;
        it.id = id; it.data = d; it.pe = pe; it.pt = pt;
        pend.push_back(it);
        batch.push_back(it);
    endtask

    // Reference: each grant goes to the first requester with work, searching from last winner + 1.
    task automatic commit();
        while (batch.size() > 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                int f;
                i = (mp + k) % N;
                f = -1;
                for (int j = 0; j < batch.size(); j++)
                    if (batch[j].id == i) begin f = j; break; end
                if (f >= 0) begin
                    eq.push_back(batch[f]);
                    batch.delete(f);
                    mp = (i + 1) % N;
                    break;
                end
            end
        end
        drive_reqs();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        pend.delete(); batch.delete(); eq.delete(); dq.delete();
        mp = 0;
        drive_reqs();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic wait_idle(string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (pend.size() == 0 && eq.size() == 0 && dq.size() == 0 && !arb_busy && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) ev_fail({name, "_drain_timeout"});
    endtask

    task automatic wait_busy(logic lvl, string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (tx_busy == lvl) begin ok = 1'b1; break; end
        end
        if (!ok) ev_fail({name, "_busy_wait"});
    endtask

    // Requesters retire their head item on ack and present the next one.
    initial forever begin
        @(negedge CLK);
        if (RST && |ack)
            for (int i = 0; i < N; i++)
                if (ack[i])
                    for (int j = 0; j < pend.size(); j++)
                        if (pend[j].id == i) begin pend.delete(j); break; end
        drive_reqs();
    end

    // UART TX model: busy for start + data + optional parity + stop bit times.
    initial forever begin
        logic [DW-1:0] d;
        logic pe, pt;
        bit ok, ab;
        int dly;
        @(negedge CLK);
        if (RST && tx_data_valid && !tie_low) begin
            d = tx_p_data; pe = tx_par_en; pt = tx_par_typ;
            ok = 1'b1; ab = 1'b0;
            dly = $urandom_range(1, 3);
            repeat (dly) @(posedge CLK);
            #1 tx_busy = 1'b1;
            repeat (DW + 2 + int'(pe)) begin
                @(negedge CLK);
                if (!RST) ab = 1'b1;
                else if (tx_p_data !== d || tx_par_en !== pe || tx_par_typ !== pt) ok = 1'b0;
            end
            @(posedge CLK);
            #1 tx_busy = 1'b0;
            if (!ab) chk("frame_stable", 64'(ok), 64'd1);
        end
    end

    // Monitor: compare every launch/done/timeout against the scoreboard.
    initial forever begin
        @(negedge CLK);
        if (RST) begin
            if (tx_data_valid) begin
                if (eq.size() == 0) ev_fail("launch_unexpected");
                else begin
                    item_t e;
                    e = eq.pop_front();
                    chk("launch_ack", 64'(ack), 64'(1 << e.id));
                    chk("launch_owner", 64'(owner_id), 64'(e.id));
                    chk("launch_data", 64'(tx_p_data), 64'(e.data));
                    chk("launch_par_en", 64'(tx_par_en), 64'(e.pe));
                    chk("launch_par_typ", 64'(tx_par_typ), 64'(e.pt));
                    dq.push_back(e.id);
                end
            end else if (|ack)
                chk("ack_without_launch", 64'(ack), 64'd0);
            if (|done) begin
                if (dq.size() == 0) ev_fail("done_unexpected");
                else chk("done_owner", 64'(done), 64'(1 << dq.pop_front()));
            end
            if (timeout_err) begin
                if (!exp_to || dq.size() == 0) ev_fail("timeout_unexpected");
                else chk("timeout_owner", 64'(owner_id), 64'(dq.pop_front()));
            end
        end
    end

    initial begin
        int l, d, a;
        bit seen;
        #2 RST = 1'b0;
        #1 chk("reset_outputs", 64'({ack, done, tx_data_valid, tx_p_data, tx_par_en, tx_par_typ,
                                      owner_id, arb_busy, timeout_err}), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // single requester, latency and latched config
        @(negedge CLK);
        load(2, 8'hA5, 1'b1, 1'b1);
        commit();
        @(negedge CLK);
        chk("t1_ack_latency", 64'(ack), 64'b0100);
        chk("t1_valid", 64'(tx_data_valid), 64'd1);
        @(negedge CLK);
        chk("t1_valid_pulse", 64'(tx_data_valid), 64'd0);
        wait_idle("t1");
        chk("t1_owner", 64'(owner_id), 64'd2);

        // all requesting from a fresh pointer; requester 0 keeps requesting
        do_reset();
        load(0, 8'h10, 1'b0, 1'b0);
        load(0, 8'h10, 1'b0, 1'b0);
        load(1, 8'h11, 1'b1, 1'b0);
        load(2, 8'h12, 1'b0, 1'b1);
        load(3, 8'h13, 1'b1, 1'b1);
        commit();
        wait_idle("t2");

        // parity off then parity on/even
        load(0, 8'h3C, 1'b0, 1'b1);
        load(1, 8'hC3, 1'b1, 1'b0);
        commit();
        wait_idle("t6");

        repeat (8) begin
            for (int i = 0; i < N; i++) begin
                int n;
                n = $urandom_range(0, 3);
                repeat (n) load(i, 8'($urandom), 1'($urandom), 1'($urandom));
            end
            commit();
            wait_idle("rand");
        end

        // request arriving mid-frame waits for done + gap
        load(1, 8'h5A, 1'b1, 1'b0);
        commit();
        wait_busy(1'b1, "t5");
        load(0, 8'h77, 1'b0, 1'b0);
        commit();
        repeat (3) @(negedge CLK);
        chk("t5_data_hold", 64'(tx_p_data), 64'h5A);
        chk("t5_no_early_ack", 64'(ack), 64'd0);
        seen = 1'b0; d = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (done[1]) begin seen = 1'b1; d = cyc; break; end
        end
        if (!seen) ev_fail("t5_done_wait");
        seen = 1'b0; a = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (ack[0]) begin seen = 1'b1; a = cyc; break; end
        end
        if (!seen) ev_fail("t5_ack_wait");
        chk("t5_ack_spacing", 64'(a - d), 64'(GAP + 2));
        wait_idle("t5");

        // UART never goes busy
        tie_low = 1'b1;
        load(1, 8'hE1, 1'b0, 1'b0);
        commit();
        seen = 1'b0; l = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (tx_data_valid) begin seen = 1'b1; l = cyc; break; end
        end
        if (!seen) ev_fail("t3_launch_wait");
        exp_to = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (timeout_err) begin seen = 1'b1; break; end
        end
        if (!seen) ev_fail("t3_timeout_wait");
        chk("t3_timeout_latency", 64'(cyc - l), 64'(TO + 1));
        repeat (GAP) @(negedge CLK);
        chk("t3_gap_busy", 64'(arb_busy), 64'd1);
        @(negedge CLK);
        chk("t3_idle", 64'(arb_busy), 64'd0);
        exp_to = 1'b0;
        tie_low = 1'b0;
        wait_idle("t3");

        // reset in the middle of a frame
        load(1, 8'h99, 1'b1, 1'b1);
        commit();
        wait_busy(1'b1, "t4");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1 chk("t4_async_reset", 64'({ack, done, tx_data_valid, tx_p_data, tx_par_en, tx_par_typ,
                                       owner_id, arb_busy, timeout_err}), 64'd0);
        pend.delete(); batch.delete(); eq.delete(); dq.delete();
        mp = 0;
        drive_reqs();
        wait_busy(1'b0, "t4_release");
        @(negedge CLK);
        RST = 1'b1;
        load(0, 8'h01, 1'b0, 1'b0);
        load(3, 8'h03, 1'b1, 1'b1);
        commit();
        wait_idle("t4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
